// File: rtl/uart_boot_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_boot_loader: 8N1 serial receiver and framed image loader for TCM  |
// | Holds the core in reset until a checksummed image has been written.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int MEM_WORDS    = 16384,
    parameter int AW           = 14
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          rxd_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          core_rstn_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);
    localparam int                 c_cw   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0]    c_half = c_cw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cw-1:0]    c_full = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [7:0]         c_sync = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_SYNC, P_LEN0, P_LEN1, P_DATA, P_CSUM, P_DONE, P_ERR} p_state_t;

    rx_state_t       r_rx_state, w_rx_nxt;
    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_cw-1:0] r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_rx_shift;
    logic            r_byte_vld, r_frame_err;
    logic            w_half, w_bit_end;

    assign w_half    = (r_clk_cnt == c_half);
    assign w_bit_end = (r_clk_cnt == c_full);

    always_comb begin
        w_rx_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_nxt = RX_START;
            RX_START: if (w_half) w_rx_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_rx_nxt = RX_STOP;
            RX_STOP:  if (w_bit_end) w_rx_nxt = RX_IDLE;
            default:  w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rx_state <= RX_IDLE;
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_shift <= '0;
            r_byte_vld <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_nxt;
            r_rx_meta   <= rxd_i;
            r_rx_sync   <= r_rx_meta;
            r_rx_prev   <= r_rx_sync;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            // Counter restarts at each sample point so later samples land on bit centres
            if (r_rx_state == RX_IDLE || (r_rx_state == RX_START && w_half) || w_bit_end)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + c_cw'(1);
            if (r_rx_state == RX_START)
                r_bit_idx <= '0;
            if (r_rx_state == RX_DATA && w_bit_end) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_bit_idx  <= r_bit_idx + 3'd1;
            end
            if (r_rx_state == RX_STOP && w_bit_end) begin
                if (r_rx_sync) r_byte_vld  <= 1'b1;
                else           r_frame_err <= 1'b1;
            end
        end
    end

    p_state_t    r_state, w_state_nxt;
    logic [15:0] r_len, r_idx, w_len, w_idx_inc;
    logic [7:0]  r_sum, w_sum_nxt;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;
    logic        w_active, w_nxt_active;

    assign w_len     = {r_rx_shift, r_len[7:0]};
    assign w_idx_inc = r_idx + 16'd1;
    assign w_sum_nxt = r_sum + r_rx_shift;
    assign w_active  = (r_state == P_LEN0) || (r_state == P_LEN1) ||
                       (r_state == P_DATA) || (r_state == P_CSUM);
    assign w_nxt_active = (w_state_nxt == P_LEN0) || (w_state_nxt == P_LEN1) ||
                          (w_state_nxt == P_DATA) || (w_state_nxt == P_CSUM);

    always_comb begin
        w_state_nxt = r_state;
        if (r_frame_err && w_active) begin
            w_state_nxt = P_ERR;
        end else if (r_byte_vld) begin
            case (r_state)
                P_SYNC: if (r_rx_shift == c_sync) w_state_nxt = P_LEN0;
                P_LEN0: w_state_nxt = P_LEN1;
                P_LEN1: begin
                    if (32'(w_len) > 32'(MEM_WORDS)) w_state_nxt = P_ERR;
                    else if (w_len == 16'd0)         w_state_nxt = P_CSUM;
                    else                             w_state_nxt = P_DATA;
                end
                P_DATA: if (r_byte_cnt == 2'd3 && w_idx_inc == r_len) w_state_nxt = P_CSUM;
                P_CSUM: w_state_nxt = (w_sum_nxt == 8'd0) ? P_DONE : P_ERR;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= P_SYNC;
            r_len       <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            core_rstn_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            mem_we_o    <= 1'b0;
            busy_o      <= w_nxt_active;
            done_o      <= (w_state_nxt == P_DONE);
            err_o       <= (w_state_nxt == P_ERR);
            core_rstn_o <= (w_state_nxt == P_DONE);
            if (r_byte_vld) begin
                case (r_state)
                    P_SYNC: if (r_rx_shift == c_sync) begin
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_byte_cnt <= '0;
                    end
                    P_LEN0: begin
                        r_len[7:0] <= r_rx_shift;
                        r_sum      <= w_sum_nxt;
                    end
                    P_LEN1: begin
                        r_len[15:8] <= r_rx_shift;
                        r_sum       <= w_sum_nxt;
                    end
                    P_DATA: begin
                        r_sum      <= w_sum_nxt;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Bytes arrive LSB first, so shift in from the top
                        if (r_byte_cnt == 2'd3) begin
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= r_idx[AW-1:0];
                            mem_wdata_o <= {r_rx_shift, r_word};
                            r_idx       <= w_idx_inc;
                        end else begin
                            r_word <= {r_rx_shift, r_word[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot-time program loader sitting directly upstream of the SCR1 TCM in `mpei_rv_core_wrp`. It receives a framed program image over a dedicated 8N1 serial line, writes it word by word into the TCM through a simple write port, and holds the core in reset until the image has loaded with a valid checksum. On silicon it is the image source for the TCM, with no dependence on simulator back-door preloading.

## Interface
Parameters:
- `CLKS_PER_BIT`, 87, clk_i cycles per serial bit (10 MHz / 115200); minimum 8.
- `MEM_WORDS`, 16384, TCM depth in 32-bit words; maximum accepted image length.
- `AW`, 14, word-address width; AW = clog2(MEM_WORDS).

Ports:
- `clk_i`  in  1  system clock; the block has one clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `rxd_i`  in  1  serial input, idle high, asynchronous to clk_i.
- `mem_we_o`  out  1  TCM write strobe, one-cycle pulse.
- `mem_addr_o`  out  AW  TCM word address.
- `mem_wdata_o`  out  32  TCM write data.
- `core_rstn_o`  out  1  active-low reset to the SCR1 core.
- `busy_o`  out  1  high from the sync byte until done or error.
- `done_o`  out  1  sticky; image loaded and checksum correct.
- `err_o`  out  1  sticky; protocol, length or framing error.

## Operation
- Receiver:
  - `rxd_i` passes through a 2-FF synchronizer.
  - IDLE: a high→low transition starts a bit-period counter.
  - At CLKS_PER_BIT/2 the start bit is re-sampled. If it reads high, the event is a glitch: return to IDLE with no byte produced.
  - Eight data bits are sampled at bit centres, every CLKS_PER_BIT, LSB first. The stop bit is sampled the same way.
  - After a stop-bit sample the receiver returns to IDLE immediately and can accept the next start edge.
  - Stop bit = 1: an internal `byte_vld` pulse is produced for one cycle. Stop bit = 0: a framing error.
- Frame format, in byte order:
  - sync byte 0xA5;
  - LEN_L, then LEN_H: word count N, 16 bits, little-endian;
  - 4·N data bytes, each word little-endian (first byte → [7:0], fourth byte → [31:24]);
  - CSUM: chosen so the 8-bit sum of LEN_L, LEN_H, all data bytes and CSUM is 0x00.
- Protocol FSM states: SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - SYNC: bytes other than 0xA5 are discarded; framing errors are ignored. 0xA5 → LEN0, `busy_o`=1, running sum and word index cleared.
  - LEN0 → LEN1: LEN_L is stored.
  - LEN1: N > MEM_WORDS → ERR. N = 0 → CSUM. Otherwise → DATA.
  - DATA: a 2-bit byte counter assembles the word. On the fourth byte, the write is issued and the word index increments. The index reaching N → CSUM.
  - CSUM: sum including CSUM equals 0x00 → DONE; otherwise → ERR.
  - DONE and ERR are terminal until `rstn_i` is asserted; all further serial input is ignored.
  - A framing error in LEN0, LEN1, DATA or CSUM → ERR.
- Writes already issued are not undone on error.
- Arithmetic:
  - the running sum is 8-bit, wrap-around;
  - the word index is 16-bit and compared against N;
  - `mem_addr_o` = index[AW-1:0], starting at 0.

## Timing
- Reset values:
  - `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0;
  - `core_rstn_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0;
  - FSM in SYNC, receiver in IDLE.
- `byte_vld` is asserted in the cycle after the stop-bit sample.
- `mem_we_o` pulses in the cycle after the `byte_vld` of the fourth byte of a word. `mem_addr_o` and `mem_wdata_o` are valid in the same cycle and hold their value until the next write.
- The cycle after the CSUM `byte_vld`:
  - on a valid checksum, `done_o`=1, `busy_o`=0, `core_rstn_o`=1;
  - on a bad checksum, `err_o`=1, `busy_o`=0, `core_rstn_o` stays 0.
- `core_rstn_o` is a registered output and never glitches. It goes high only from DONE.
- Reset in the middle of a load clears all state asynchronously, including any partial word and the sum. The next load begins from SYNC.
- Minimum character spacing is back-to-back: a stop bit is followed directly by the next start bit.

## Test plan
- Two-word load. Stimulus: A5 02 00 78 56 34 12 EF BE AD DE B2. Required response:
  - writes (addr 0, 0x12345678), then (addr 1, 0xDEADBEEF);
  - then `done_o`=1 and `core_rstn_o`=1;
  - `err_o`=0 throughout.
- Noise before sync, then empty image. Stimulus: 00 FF 5A, then A5 00 00 00. Required response: no writes, `busy_o` rises only on A5, `done_o`=1, `core_rstn_o`=1.
- Bad checksum. Stimulus: the first scenario's frame with CSUM 0xB3. Required response: both writes occur, `err_o`=1, `core_rstn_o` stays 0, and subsequent frames are ignored.
- Oversize image. Stimulus: A5 01 40 (N = 0x4001). Required response: `err_o`=1 in the cycle after LEN_H `byte_vld`, and `mem_we_o` never pulses.
- Line errors:
  - a `rxd_i` low pulse of CLKS_PER_BIT/4 cycles in SYNC produces no byte;
  - a data byte with stop bit 0 during DATA sets `err_o`=1.
- Reset mid-load. Stimulus: `rstn_i` asserted after 6 data bytes. Required response:
  - all outputs return to reset values immediately;
  - a full two-word frame sent afterwards loads at addr 0/1 and sets `done_o`.
